fa_result_accumulator: RTL

- Downstream consumer of the 2-stage pipelined 2-bit full adder.
- Takes each 3-bit result {c_out,s} that the adder produces, with a valid strobe, and buffers it in a 2-entry FIFO. The FIFO absorbs the adder's 2-cycle in-flight results when backpressure occurs.
- Sums BLOCK_LEN consecutive results into one wide total and presents that total on a valid/ready output port, with overflow and drop flags.

---
 rtl/fa_result_accumulator.sv | 119 +++++++++++
 1 files changed

// File: rtl/fa_result_accumulator.sv
// Buffers {c_out,s} results from the pipelined full adder in a 2-entry FIFO and
// sums BLOCK_LEN of them into one wide total offered on a valid/ready port.
module fa_result_accumulator #(
  parameter int IN_W      = 3,
  parameter int ACC_W     = 8,
  parameter int BLOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             drop_err
);

  localparam int SUM_W = ACC_W + 1;
  localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer side never waits on a pop, and out_sum/out_ovf hold while stalled.
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IN_W-1:0]  mem_q [2];
  logic [1:0]       occ_q, occ_d;
  logic             wr_ptr_q, rd_ptr_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;
  logic             drop_q;

  logic             full, empty, push, pop, last;
  logic [IN_W-1:0]  head;
  logic [SUM_W-1:0] sum;

  always_comb begin
    full  = (occ_q == 2'd2);
    empty = (occ_q == 2'd0);
    push  = in_valid && !full;
    pop   = (state_q == ACCUM) && !empty;
    head  = mem_q[rd_ptr_q];
    sum   = SUM_W'(acc_q) + SUM_W'(head);
    last  = (cnt_q == CNT_W'(BLOCK_LEN - 1));
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;
    occ_d     = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    if (pop) begin
      if (last) begin
        out_sum_d = sum[ACC_W-1:0];
        out_ovf_d = ovf_q | sum[ACC_W];
        acc_d     = '0;
        cnt_d     = '0;
        ovf_d     = 1'b0;
        state_d   = HOLD;
      end else begin
        acc_d = sum[ACC_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        ovf_d = ovf_q | sum[ACC_W];
      end
    end
    if (state_q == HOLD && out_ready) state_d = ACCUM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCUM;
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      occ_q     <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      occ_q     <= occ_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      if (in_valid && full) drop_q <= 1'b1;
    end
  end

  assign in_ready  = !full;
  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign drop_err  = drop_q;

endmodule
